// File: rtl/exa_crosb_output_arbiter_vc.sv
// Crossbar output-port arbiter with strict priority classes, per-class
// round-robin, packet-level grant holding and per-VC credit tracking.
module exa_crosb_output_arbiter_vc #(
  parameter int unsigned input_num  = 4,
  parameter int unsigned prio_num   = 2,
  parameter int unsigned vc_num     = 2,
  parameter int unsigned fifo_depth = 8,
  localparam int unsigned VcTot = prio_num * vc_num,
  localparam int unsigned InW   = (input_num > 1) ? $clog2(input_num) : 1,
  localparam int unsigned VcW   = (VcTot > 1) ? $clog2(VcTot) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [input_num-1:0][VcTot-1:0]     i_request,
  input  logic [input_num-1:0]                i_valid,
  input  logic [input_num-1:0]                i_last,
  input  logic [VcTot-1:0]                    i_credit_return,
  output logic [input_num-1:0]                o_grant,
  output logic [InW-1:0]                      o_sel_input,
  output logic [VcW-1:0]                      o_sel_vc,
  output logic [VcTot-1:0]                    o_credits,
  output logic                                o_credit_err
);

  localparam int unsigned PrioW = (prio_num > 1) ? $clog2(prio_num) : 1;
  localparam int unsigned CntW  = $clog2(fifo_depth + 1);

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e             state_q;
  logic [InW-1:0]     owner_q;
  logic [VcW-1:0]     owner_vc_q;
  logic [PrioW-1:0]   owner_prio_q;
  logic [InW-1:0]     ptr_q [prio_num];
  logic [CntW-1:0]    cnt_q [VcTot];
  logic               err_q;

  logic [VcTot-1:0]     credit_nz;
  logic [input_num-1:0] elig [prio_num];
  logic                 win_found;
  logic [InW-1:0]       win_idx;
  logic [VcW-1:0]       win_vc;
  logic [PrioW-1:0]     win_prio;
  logic                 act;
  logic [InW-1:0]       cur_idx;
  logic [VcW-1:0]       cur_vc;
  logic [PrioW-1:0]     cur_prio;
  logic                 xfer;
  logic                 done;

  // Credit availability per VC.
  always_comb begin
    credit_nz = '0;
    for (int unsigned v = 0; v < VcTot; v++) begin
      credit_nz[v] = (cnt_q[v] != '0);
    end
  end

  // Strict-priority class pick, then round-robin from the class pointer.
  always_comb begin : p_arb
    int unsigned rr_idx;
    rr_idx    = 0;
    win_found = 1'b0;
    win_prio  = '0;
    win_idx   = '0;
    win_vc    = '0;
    for (int unsigned p = 0; p < prio_num; p++) begin
      elig[p] = '0;
      for (int unsigned n = 0; n < input_num; n++) begin
        elig[p][n] = |(i_request[n][p*vc_num +: vc_num] & credit_nz[p*vc_num +: vc_num]);
      end
      // Ascending scan, so the highest eligible class is the one left standing.
      if (|elig[p]) begin
        win_found = 1'b1;
        win_prio  = PrioW'(p);
      end
    end
    // Descending scan so the smallest offset from the pointer wins.
    for (int k = int'(input_num) - 1; k >= 0; k--) begin
      rr_idx = (32'(ptr_q[win_prio]) + 32'(k)) % input_num;
      if (elig[win_prio][rr_idx]) win_idx = InW'(rr_idx);
    end
    for (int unsigned v = 0; v < VcTot; v++) begin
      if (i_request[win_idx][v] && credit_nz[v] && ((v / vc_num) == 32'(win_prio))) begin
        win_vc = VcW'(v);
      end
    end
    if (!win_found) begin
      win_idx = '0;
      win_vc  = '0;
    end
  end

  // Grant source: live arbitration while idle, registered owner while granted.
  always_comb begin
    if (state_q == StGranted) begin
      act      = 1'b1;
      cur_idx  = owner_q;
      cur_vc   = owner_vc_q;
      cur_prio = owner_prio_q;
    end else begin
      act      = win_found;
      cur_idx  = win_idx;
      cur_vc   = win_vc;
      cur_prio = win_prio;
    end
    xfer = act && !reset && i_valid[cur_idx];
    done = xfer && i_last[cur_idx];

    o_grant     = '0;
    o_sel_input = '0;
    o_sel_vc    = '0;
    if (act && !reset) begin
      o_grant[cur_idx] = 1'b1;
      o_sel_input      = cur_idx;
      o_sel_vc         = cur_vc;
    end
    o_credits    = credit_nz;
    o_credit_err = err_q;
  end

  // Packet ownership FSM; a single-word packet never leaves idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      owner_vc_q   <= '0;
      owner_prio_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            owner_q      <= win_idx;
            owner_vc_q   <= win_vc;
            owner_prio_q <= win_prio;
            if (!(i_valid[win_idx] && i_last[win_idx])) state_q <= StGranted;
          end
        end
        StGranted: begin
          if (i_valid[owner_q] && i_last[owner_q]) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Round-robin pointers move past the owner only when its packet completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned p = 0; p < prio_num; p++) ptr_q[p] <= '0;
    end else if (done) begin
      ptr_q[cur_prio] <= (cur_idx == InW'(input_num - 1)) ? '0 : cur_idx + InW'(1);
    end
  end

  // Credit counters: forwarded word consumes, return pulse frees, overflow is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned v = 0; v < VcTot; v++) cnt_q[v] <= CntW'(fifo_depth);
      err_q <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < VcTot; v++) begin
        if (xfer && (cur_vc == VcW'(v)) && !i_credit_return[v]) begin
          // Packet may run past zero credits; the counter just floors.
          if (cnt_q[v] != '0) cnt_q[v] <= cnt_q[v] - CntW'(1);
        end else if (i_credit_return[v] && !(xfer && (cur_vc == VcW'(v)))) begin
          if (cnt_q[v] == CntW'(fifo_depth)) err_q <= 1'b1;
          else cnt_q[v] <= cnt_q[v] + CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_exa_crosb_output_arbiter_vc.sv
// Directed bench for the crossbar output arbiter with a grant scoreboard.
module tb_exa_crosb_output_arbiter_vc;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][3:0]  i_request;
  logic [3:0]       i_valid;
  logic [3:0]       i_last;
  logic [3:0]       i_credit_return;
  logic [3:0]       o_grant;
  logic [1:0]       o_sel_input;
  logic [1:0]       o_sel_vc;
  logic [3:0]       o_credits;
  logic             o_credit_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  exa_crosb_output_arbiter_vc dut (
    .clk             (clk),
    .reset           (reset),
    .i_request       (i_request),
    .i_valid         (i_valid),
    .i_last          (i_last),
    .i_credit_return (i_credit_return),
    .o_grant         (o_grant),
    .o_sel_input     (o_sel_input),
    .o_sel_vc        (o_sel_vc),
    .o_credits       (o_credits),
    .o_credit_err    (o_credit_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input logic [3:0] g, input logic [1:0] si,
                                     input logic [1:0] sv);
    return {24'b0, g, si, sv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected grant tuple, sample combinational outputs mid-cycle,
  // pop and compare, then advance to the next falling edge.
  task automatic step(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, pk(o_grant, o_sel_input, o_sel_vc), e);
    @(negedge clk);
  endtask

  task automatic clear_in();
    i_request       = '0;
    i_valid         = '0;
    i_last          = '0;
    i_credit_return = '0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    @(negedge clk);
    // Outputs stay quiet during reset even with a live request.
    i_request[0] = 4'b0001;
    #1;
    chk("rst_grant", {28'b0, o_grant}, 32'h0);
    chk("rst_credits", {28'b0, o_credits}, 32'hF);
    chk("rst_err", {31'b0, o_credit_err}, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_in();
    @(negedge clk);

    // High-priority input 3 beats low-priority inputs 0 and 2.
    i_request[0] = 4'b0010;
    i_request[2] = 4'b0010;
    i_request[3] = 4'b0100;
    step("prio_grant", pk(4'b1000, 2'd3, 2'd2));
    chk("prio_state_granted", 32'(dut.state_q), 32'd1);
    clear_in();
    step("prio_hold", pk(4'b1000, 2'd3, 2'd2));
    i_valid = 4'b1000;
    i_last  = 4'b1000;
    step("prio_last", pk(4'b1000, 2'd3, 2'd2));
    clear_in();
    chk("prio_state_idle", 32'(dut.state_q), 32'd0);
    chk("prio_ptr1", 32'(dut.ptr_q[1]), 32'd0);
    chk("prio_cnt2", 32'(dut.cnt_q[2]), 32'd7);
    i_credit_return = 4'b0100;
    step("idle_no_req", pk(4'b0, 2'd0, 2'd0));
    clear_in();
    chk("cnt2_restored", 32'(dut.cnt_q[2]), 32'd8);

    // Round-robin between inputs 0 and 1 with 3-word VC0 packets.
    for (int pkt = 0; pkt < 4; pkt++) begin
      for (int w = 0; w < 3; w++) begin
        i_request[0]    = 4'b0001;
        i_request[1]    = 4'b0001;
        i_valid         = 4'(1 << (pkt % 2));
        i_last          = (w == 2) ? i_valid : 4'b0;
        i_credit_return = 4'b0001;
        step($sformatf("rr_p%0d_w%0d", pkt, w), pk(4'(1 << (pkt % 2)), 2'(pkt % 2), 2'd0));
      end
      chk($sformatf("rr_p%0d_idle", pkt), 32'(dut.state_q), 32'd0);
    end
    clear_in();
    chk("rr_cnt0", 32'(dut.cnt_q[0]), 32'd8);
    chk("rr_ptr0", 32'(dut.ptr_q[0]), 32'd2);

    // Single-word packet: grant for one cycle, no state change.
    i_request[1] = 4'b0001;
    i_valid      = 4'b0010;
    i_last       = 4'b0010;
    step("single_grant", pk(4'b0010, 2'd1, 2'd0));
    clear_in();
    chk("single_state", 32'(dut.state_q), 32'd0);
    chk("single_cnt0", 32'(dut.cnt_q[0]), 32'd7);
    step("single_release", pk(4'b0, 2'd0, 2'd0));
    i_credit_return = 4'b0001;
    step("refill_idle", pk(4'b0, 2'd0, 2'd0));
    clear_in();

    // Drain VC0 credits with an 8-word packet from input 2.
    for (int w = 0; w < 8; w++) begin
      i_request[2] = 4'b0001;
      i_valid      = 4'b0100;
      i_last       = (w == 7) ? 4'b0100 : 4'b0000;
      step($sformatf("drain_w%0d", w), pk(4'b0100, 2'd2, 2'd0));
    end
    clear_in();
    chk("drain_credits", {28'b0, o_credits}, 32'hE);
    i_request[0] = 4'b0001;
    step("blocked", pk(4'b0, 2'd0, 2'd0));
    i_credit_return = 4'b0001;
    step("blocked_ret", pk(4'b0, 2'd0, 2'd0));
    i_credit_return = 4'b0000;
    chk("ret_credits", {28'b0, o_credits}, 32'hF);
    i_valid = 4'b0001;
    i_last  = 4'b0001;
    step("unblocked", pk(4'b0001, 2'd0, 2'd0));
    clear_in();

    // Credit overflow on VC3 is sticky.
    i_credit_return = 4'b1000;
    step("ovf_pulse", pk(4'b0, 2'd0, 2'd0));
    clear_in();
    chk("ovf_err", {31'b0, o_credit_err}, 32'h1);
    chk("ovf_cnt3", 32'(dut.cnt_q[3]), 32'd8);
    step("ovf_wait", pk(4'b0, 2'd0, 2'd0));
    chk("ovf_sticky", {31'b0, o_credit_err}, 32'h1);

    // Reset mid-packet with VC2 at 5 credits.
    for (int w = 0; w < 3; w++) begin
      i_request[3] = 4'b0100;
      i_valid      = 4'b1000;
      step($sformatf("mid_w%0d", w), pk(4'b1000, 2'd3, 2'd2));
    end
    chk("mid_cnt2", 32'(dut.cnt_q[2]), 32'd5);
    chk("mid_state", 32'(dut.state_q), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_grant", {28'b0, o_grant}, 32'h0);
    chk("mid_rst_state", 32'(dut.state_q), 32'd0);
    chk("mid_rst_credits", {28'b0, o_credits}, 32'hF);
    @(negedge clk);
    reset = 1'b0;
    clear_in();
    for (int v = 0; v < 4; v++) chk($sformatf("post_cnt%0d", v), 32'(dut.cnt_q[v]), 32'd8);
    for (int p = 0; p < 2; p++) chk($sformatf("post_ptr%0d", p), 32'(dut.ptr_q[p]), 32'd0);
    chk("post_err", {31'b0, o_credit_err}, 32'h0);
    step("post_idle", pk(4'b0, 2'd0, 2'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exa_crosb_output_arbiter_vc.md
EXA_CROSB_OUTPUT_ARBITER_VC -- requirements
Module: exa_crosb_output_arbiter_vc

Interface
REQ-001 SHALL have parameter input_num, default 4, meaning the number of crossbar inputs competing for this output.
REQ-002 SHALL have parameter prio_num, default 2, meaning the number of priority classes; the highest index is the highest priority.
REQ-003 SHALL have parameter vc_num, default 2, meaning the number of VCs per priority class; output VC index = prio*vc_num + vc.
REQ-004 SHALL have parameter fifo_depth, default 8, meaning the output FIFO words per output VC, which is also the initial credit count.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_request, input, [prio_num*vc_num-1:0] x input_num: per input, one-hot output VC requested; all-zero = no request.
REQ-008 SHALL have port i_valid, input, [input_num-1:0]: per input, data word present on the crossbar this cycle.
REQ-009 SHALL have port i_last, input, [input_num-1:0]: per input, the current word is the packet's last; qualified by i_valid.
REQ-010 SHALL have port i_credit_return, input, [prio_num*vc_num-1:0]: one-cycle pulse per VC, one FIFO word freed.
REQ-011 SHALL have port o_grant, output, [input_num-1:0]: one-hot grant to the winning input.
REQ-012 SHALL have port o_sel_input, output, log2(input_num): binary index of the granted input, used as the crossbar mux select.
REQ-013 SHALL have port o_sel_vc, output, log2(prio_num*vc_num): output VC of the granted packet.
REQ-014 SHALL have port o_credits, output, [prio_num*vc_num-1:0]: bit v high when the credit count of VC v is nonzero.
REQ-015 SHALL have port o_credit_err, output, 1 bit: sticky flag for a credit overflow.

Function
REQ-016 SHALL implement an FSM with states IDLE and GRANTED.
REQ-017 A request from input n for VC v SHALL be eligible only when the credit count of v is nonzero.
REQ-018 Priority enforcement SHALL pick the highest priority class holding any eligible request; lower classes SHALL be ignored that cycle.
REQ-019 Within the chosen class, a per-class round-robin pointer SHALL pick the first eligible input at or after the pointer, wrapping from input_num-1 to 0.
REQ-020 In IDLE, o_grant, o_sel_input and o_sel_vc SHALL be driven combinationally in the same cycle as the request (zero latency) so that the input side can assert cts that cycle.
REQ-021 In IDLE, when a winner exists, the owner input and VC SHALL be registered and the FSM SHALL go to GRANTED, unless the winner has i_valid and i_last that same cycle, in which case the FSM SHALL stay IDLE.
REQ-022 In GRANTED, o_grant, o_sel_input and o_sel_vc SHALL come from the registered owner, independent of i_request.
REQ-023 In GRANTED, owner i_valid with i_last SHALL return the FSM to IDLE at the next edge; a new arbitration may occur in that following cycle.
REQ-024 On packet completion (owner valid and last, including the single-word case), the winning class's pointer SHALL advance to owner+1 mod input_num; other class pointers SHALL be unchanged.
REQ-025 Each cycle, the credit count of v SHALL decrement by 1 when o_grant is set for an input with i_valid and the selected VC is v.
REQ-026 Each cycle, the credit count of v SHALL increment by 1 on i_credit_return[v].
REQ-027 A simultaneous decrement and return on the same VC SHALL leave the count unchanged.
REQ-028 A return with the count at fifo_depth and no decrement SHALL hold the count at fifo_depth and set o_credit_err.
REQ-029 A packet in progress SHALL continue even when the VC's credit count reaches 0; the sender is responsible for obeying o_credits.
REQ-030 With no eligible request in IDLE, o_grant SHALL be 0 and o_sel_input and o_sel_vc SHALL be 0.
REQ-031 Owner i_valid without i_last SHALL keep the FSM in GRANTED; i_valid from non-owners SHALL be ignored.

Reset
REQ-032 Asserting reset at any time, including mid-packet, SHALL immediately put the FSM in IDLE.
REQ-033 Reset SHALL clear all round-robin pointers to 0 and the owner registers to 0.
REQ-034 Reset SHALL set every credit count to fifo_depth and clear o_credit_err.
REQ-035 During reset, o_grant SHALL be 0 and o_credits SHALL be all ones.

Verification
REQ-036 Inputs 0 and 2 request VC1 (low prio) and input 3 requests VC2 (high prio) -> o_grant=4'b1000 and o_sel_vc=2 in the same cycle; FSM in GRANTED next cycle.
REQ-037 Inputs 0 and 1 each send repeated 3-word VC0 packets -> grants alternate 0,1,0,1; each grant is held 3 valid cycles and released after the last word.
REQ-038 Input 1 sends a single word with i_valid=i_last=1 in the request cycle -> one-cycle o_grant=4'b0010, FSM stays IDLE, VC0 credit drops 8->7.
REQ-039 Eight words are sent on VC0 with no returns -> o_credits[0]=0 and new VC0 requests are not granted; one i_credit_return[0] pulse -> o_credits[0]=1 next cycle and the request is granted.
REQ-040 i_credit_return[3] is pulsed with the credit count at 8 -> count stays 8 and o_credit_err=1 until reset.
REQ-041 Reset is asserted mid-packet with the VC2 credit count at 5 -> o_grant=0 immediately and, after release, all credit counts are 8 and the pointers are 0.
